// File: rtl/snd_mix_ctrl.sv
//------------------------------------------------------------------------------
// Module      : snd_mix_ctrl
// Description : Four-channel sound mixer. It scans the channels once per sample
//               period, applies a per-channel gain, saturates the sum and emits
//               offset-binary PCM. It also drives a master volume output.
//               Optional macro SND_MIX_RAMP_EN: volume_out ramps one step per tick.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module snd_mix_ctrl #(
  parameter int DIV = 40
) (
  input  logic        m2,
  input  logic        rst,
  input  logic [3:0]  ch_valid,
  input  logic [63:0] ch_data,
  output logic [3:0]  ch_ready,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [7:0]  cfg_data,
  output logic [15:0] pcm_out,
  output logic [7:0]  volume_out,
  output logic        sample_strobe
);

  localparam int c_DIV_W = 10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_SCAN = 3'd2,
    S_SAT  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_DIV_W-1:0]   r_div;
  logic                 w_tick;
  logic [1:0]           r_slot;
  logic [3:0][7:0]      r_gain;
  logic [3:0][7:0]      r_sgain;
  logic [7:0]           r_master;
  logic                 r_enable;
  logic                 w_enable_nxt;
  logic signed [15:0]   r_hold [4];
  logic signed [18:0]   r_acc;
  logic signed [15:0]   r_sat;
  logic signed [15:0]   w_sample;
  logic signed [24:0]   w_prod;
  logic signed [18:0]   w_contrib;
  logic signed [15:0]   w_clamp;
  logic [7:0]           w_vol_target;

  assign w_tick = (r_div == c_DIV_W'(DIV - 1));

  // A control write in the same cycle as a tick must win over frame start.
  assign w_enable_nxt = (cfg_we && cfg_addr == 3'd5) ? cfg_data[0] : r_enable;

  assign w_sample  = ch_valid[r_slot] ? ch_data[{r_slot, 4'd0} +: 16] : r_hold[r_slot];
  assign w_prod    = w_sample * $signed({1'b0, r_sgain[r_slot]});
  assign w_contrib = 19'(w_prod >>> 7);

  always_comb begin
    w_clamp = r_acc[15:0];
    if (r_acc > 19'sd32767)
      w_clamp = 16'sh7FFF;
    else if (r_acc < -19'sd32768)
      w_clamp = 16'sh8000;
  end

  assign w_vol_target = r_enable ? r_master : 8'd0;

  always_ff @(posedge m2) begin
    if (rst) begin
      r_gain   <= {4{8'd128}};
      r_master <= 8'd0;
      r_enable <= 1'b0;
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0, 3'd1, 3'd2, 3'd3: r_gain[cfg_addr[1:0]] <= cfg_data;
        3'd4:                   r_master <= cfg_data;
        3'd5:                   r_enable <= cfg_data[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!w_enable_nxt) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_WAIT;
        S_WAIT: if (w_tick) w_state_nxt = S_SCAN;
        S_SCAN: if (r_slot == 2'd3) w_state_nxt = S_SAT;
        S_SAT:  w_state_nxt = S_OUT;
        S_OUT:  w_state_nxt = S_WAIT;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ch_ready = 4'b0000;
    if (r_state == S_SCAN)
      ch_ready[r_slot] = ch_valid[r_slot];
  end

  always_ff @(posedge m2) begin
    if (rst) begin
      r_div         <= '0;
      r_state       <= S_IDLE;
      r_slot        <= 2'd0;
      r_sgain       <= {4{8'd128}};
      r_acc         <= '0;
      r_sat         <= '0;
      pcm_out       <= 16'h8000;
      sample_strobe <= 1'b0;
      for (int k = 0; k < 4; k++) r_hold[k] <= '0;
    end else begin
      r_div         <= w_tick ? '0 : r_div + 1'b1;
      r_state       <= w_state_nxt;
      sample_strobe <= 1'b0;
      if (w_state_nxt == S_IDLE) begin
        // Entering or staying idle also covers a mid-frame abort.
        r_slot  <= 2'd0;
        pcm_out <= 16'h8000;
        for (int k = 0; k < 4; k++) r_hold[k] <= '0;
      end else begin
        case (r_state)
          S_WAIT: begin
            if (w_tick) begin
              r_sgain <= r_gain;
              r_acc   <= '0;
              r_slot  <= 2'd0;
            end
          end
          S_SCAN: begin
            r_acc  <= r_acc + w_contrib;
            r_slot <= r_slot + 2'd1;
            if (ch_valid[r_slot])
              r_hold[r_slot] <= w_sample;
          end
          S_SAT: r_sat <= w_clamp;
          S_OUT: begin
            pcm_out       <= r_sat ^ 16'h8000;
            sample_strobe <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SND_MIX_RAMP_EN
  always_ff @(posedge m2) begin
    if (rst)
      volume_out <= 8'd0;
    else if (w_tick) begin
      if (volume_out < w_vol_target)
        volume_out <= volume_out + 8'd1;
      else if (volume_out > w_vol_target)
        volume_out <= volume_out - 8'd1;
    end
  end
`else
  always_ff @(posedge m2) begin
    if (rst)
      volume_out <= 8'd0;
    else
      volume_out <= w_vol_target;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_snd_mix_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_snd_mix_ctrl
// Description : Scoreboard bench for snd_mix_ctrl with a behavioural mixer model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_snd_mix_ctrl;
  localparam int DIV = 16;
  localparam int NONE = 9;

  logic        m2 = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ch_valid = '0;
  logic [63:0] ch_data = '0;
  logic [3:0]  ch_ready;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [7:0]  cfg_data = '0;
  logic [15:0] pcm_out;
  logic [7:0]  volume_out;
  logic        sample_strobe;

  snd_mix_ctrl #(.DIV(DIV)) dut (
    .m2(m2), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .pcm_out(pcm_out),
    .volume_out(volume_out), .sample_strobe(sample_strobe)
  );

  always #5 m2 = ~m2;

  typedef struct { logic [15:0] pcm; int due; } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rst_edge = 0;

  int m_gain[4];
  int m_hold[4];
  int m_master;
  bit m_en;

  always @(posedge m2) begin
    cyc = cyc + 1;
    if (rst) rst_edge = cyc;
  end

  function automatic bit is_tick();
    return ((cyc - rst_edge) % DIV) == DIV - 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_gain[k] = 128;
      m_hold[k] = 0;
    end
    m_master = 0;
    m_en = 1'b0;
  endtask

  task automatic model_write(input logic [2:0] a, input logic [7:0] d);
    if (a < 3'd4) m_gain[a[1:0]] = int'(d);
    else if (a == 3'd4) m_master = int'(d);
    else if (a == 3'd5) begin
      m_en = d[0];
      if (!d[0]) for (int k = 0; k < 4; k++) m_hold[k] = 0;
    end
  endtask

  // Floor of x/128, i.e. what an arithmetic right shift by 7 yields.
  function automatic int floor128(input int x);
    if (x >= 0) return x / 128;
    return -((-x + 127) / 128);
  endfunction

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge m2);
    cfg_we = 1'b0;
    model_write(a, d);
  endtask

  // One sample period from tick to output. wr_at: -1 = tick cycle, 0..3 = slot, NONE.
  task automatic frame(input logic [3:0] v, input logic [63:0] d, input int wr_at,
                       input logic [2:0] wa, input logic [7:0] wd, input int want);
    int n, acc;
    int sg[4];
    bit ab;
    logic signed [15:0] smp;
    exp_t e;
    while (!is_tick()) @(negedge m2);
    n = cyc;
    chk("ready_wait", ch_ready, 4'b0000);
    ch_valid = v; ch_data = d;
    for (int k = 0; k < 4; k++) sg[k] = m_gain[k];
    ab = !m_en;
    for (int s = -1; s < 4; s++) begin
      if (s >= 0) begin
        @(negedge m2);
        cfg_we = 1'b0;
        chk($sformatf("ready_slot%0d", s), ch_ready,
            (!ab && v[s]) ? (32'd1 << s) : 32'd0);
        if (!ab && v[s]) begin
          smp = d[16*s +: 16];
          m_hold[s] = int'(smp);
        end
      end
      if (wr_at == s) begin
        cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd;
        model_write(wa, wd);
        if (wa == 3'd5 && !wd[0]) ab = 1'b1;
      end
    end
    if (!ab) begin
      acc = 0;
      for (int k = 0; k < 4; k++) acc += floor128(m_hold[k] * sg[k]);
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      e.pcm = (want >= 0) ? 16'(want) : (16'(acc) ^ 16'h8000);
      e.due = n + 7;
      exp_q.push_back(e);
    end
    @(negedge m2);
    chk("ready_sat", ch_ready, 4'b0000);
    cfg_we = 1'b0; ch_valid = '0;
    @(negedge m2);
    chk("ready_out", ch_ready, 4'b0000);
    @(negedge m2);
    if (ab) begin
      chk("abort_strobe", sample_strobe, 1'b0);
      chk("abort_pcm", pcm_out, 16'h8000);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a sample.
  always @(negedge m2) begin
    if (!rst) begin
      total++;
      if (!$onehot0(ch_ready) || (ch_ready & ~ch_valid) != 4'b0000) begin
        bad++;
        $display("FAIL ready_rule: ready=%b valid=%b (cycle %0d)", ch_ready, ch_valid, cyc);
      end
      if (sample_strobe) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe: pcm=%h (cycle %0d)", pcm_out, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (pcm_out !== e.pcm || cyc != e.due) begin
            bad++;
            $display("FAIL pcm_sample: got %h at cycle %0d want %h at cycle %0d",
                     pcm_out, cyc, e.pcm, e.due);
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] d;
    model_reset();
    repeat (3) @(negedge m2);
    rst = 1'b0;
    @(negedge m2);
    chk("rst_pcm", pcm_out, 16'h8000);
    chk("rst_vol", volume_out, 8'd0);
    chk("rst_ready", ch_ready, 4'b0000);
    chk("rst_strobe", sample_strobe, 1'b0);

    cfg_write(3'd5, 8'd1);
    frame(4'b0001, {48'd0, 16'd1000}, NONE, 0, 0, 16'h83E8);
    frame(4'b1111, {4{16'h4E20}}, NONE, 0, 0, 16'hFFFF);
    frame(4'b1111, {4{16'hB1E0}}, NONE, 0, 0, 16'h0000);

    cfg_write(3'd1, 8'd64);
    frame(4'b1111, {16'd0, 16'd0, 16'hFC18, 16'd0}, NONE, 0, 0, 16'h7E0C);
    frame(4'b1101, {16'd0, 16'd0, 16'h1234, 16'd0}, NONE, 0, 0, 16'h7E0C);
    cfg_write(3'd1, 8'd128);

    frame(4'b1111, {48'd0, 16'd1000}, 1, 3'd0, 8'd0, 16'h83E8);
    frame(4'b1111, {48'd0, 16'd1000}, NONE, 0, 0, 16'h8000);
    cfg_write(3'd0, 8'd128);

    chk("vol_before", volume_out, 8'd0);
    cfg_write(3'd4, 8'd200);
`ifdef SND_MIX_RAMP_EN
    for (int i = 1; i <= 200; i++) begin
      frame(4'b0000, '0, NONE, 0, 0, -1);
      chk($sformatf("vol_ramp%0d", i), volume_out, 8'(i));
    end
`else
    chk("vol_not_yet", volume_out, 8'd0);
    @(negedge m2);
    chk("vol_direct", volume_out, 8'd200);
`endif

    frame(4'b1111, {16'd7, 16'd300, 16'hFF00, 16'd5}, 2, 3'd5, 8'd0, -1);
    ch_valid = 4'b1111;
    for (int i = 0; i < DIV + 4; i++) begin
      @(negedge m2);
      chk("ready_disabled", ch_ready, 4'b0000);
      chk("strobe_disabled", sample_strobe, 1'b0);
    end
    ch_valid = '0;
    cfg_write(3'd5, 8'd1);
    frame(4'b0000, '0, NONE, 0, 0, 16'h8000);

    for (int i = 0; i < 24; i++) begin
      d = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0)
        frame(4'($urandom), d, $urandom_range(0, 3), 3'($urandom_range(0, 4)), 8'($urandom), -1);
      else
        frame(4'($urandom), d, NONE, 0, 0, -1);
    end

    frame(4'b1111, {4{16'h1111}}, -1, 3'd5, 8'd0, -1);
    cfg_write(3'd5, 8'd1);
    frame(4'b0000, '0, NONE, 0, 0, 16'h8000);

    while (!is_tick()) @(negedge m2);
    ch_valid = 4'b1111; ch_data = {4{16'h0400}};
    @(negedge m2);
    chk("rstscan_slot0", ch_ready, 4'b0001);
    @(negedge m2);
    chk("rstscan_slot1", ch_ready, 4'b0010);
    rst = 1'b1;
    @(negedge m2);
    chk("rstscan_ready", ch_ready, 4'b0000);
    chk("rstscan_pcm", pcm_out, 16'h8000);
    chk("rstscan_strobe", sample_strobe, 1'b0);
    chk("rstscan_vol", volume_out, 8'd0);
    rst = 1'b0; ch_valid = '0;
    model_reset();
    @(negedge m2);
    cfg_write(3'd5, 8'd1);
    frame(4'b0001, {48'd0, 16'd1000}, NONE, 0, 0, 16'h83E8);

    cfg_write(3'd5, 8'd0);
    repeat (2 * DIV) @(negedge m2);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
